// File: rtl/npu_cfg_pkg.sv
// Shared constants for the NPU config loader: field widths, the entry
// layout, target-select encodings and the loader state encoding.
package npu_cfg_pkg;

    // Field widths of one config entry {sel, pad, data}.
    localparam int CFG_SEL_W   = 4;
    localparam int CFG_DATA_W  = 16;
    localparam int CFG_PAD_W   = 6;
    localparam int CFG_ENTRY_W = CFG_SEL_W + CFG_PAD_W + CFG_DATA_W;

    // Target-select encodings carried in header bits [31:28].
    localparam logic [3:0] SEL_WEIGHT0 = 4'd0;
    localparam logic [3:0] SEL_WEIGHT1 = 4'd1;
    localparam logic [3:0] SEL_WEIGHT2 = 4'd2;
    localparam logic [3:0] SEL_WEIGHT3 = 4'd3;
    localparam logic [3:0] SEL_WEIGHT4 = 4'd4;
    localparam logic [3:0] SEL_WEIGHT5 = 4'd5;
    localparam logic [3:0] SEL_WEIGHT6 = 4'd6;
    localparam logic [3:0] SEL_WEIGHT7 = 4'd7;
    localparam logic [3:0] SEL_NONE    = 4'd8;
    localparam logic [3:0] SEL_IN_FMT  = 4'd9;
    localparam logic [3:0] SEL_OUT_FMT = 4'd10;
    localparam logic [3:0] SEL_IN_CNT  = 4'd11;
    localparam logic [3:0] SEL_OUT_CNT = 4'd12;
    localparam logic [3:0] SEL_SCHED   = 4'd13;
    localparam logic [3:0] SEL_OFFSET  = 4'd14;
    localparam logic [3:0] SEL_NPU_RST = 4'd15;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_HDR      = 3'd0,
        ST_WORD     = 3'd1,
        ST_EMIT_LO  = 3'd2,
        ST_EMIT_HI  = 3'd3,
        ST_RST_EMIT = 3'd4,
        ST_DRAIN    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/npu_config_loader.sv
// NPU config loader: parses a host command stream (header + packed 16-bit
// payload) and writes one 26-bit config entry per cycle into the config
// FIFO, stalling while the FIFO is full.
module npu_config_loader
    import npu_cfg_pkg::*;
#(
    parameter int HOST_W = 32,   // must be 2*DATA_W
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [HOST_W-1:0]                 host_din,
    input  logic                              host_valid,
    output logic                              host_ready,
    input  logic                              npu_config_fifo_full,
    output logic [SEL_W+CFG_PAD_W+DATA_W-1:0] npu_config_interface_din,
    output logic                              npu_config_fifo_write_en,
    output logic                              loader_busy,
    output logic                              loader_done,
    output logic                              loader_err
);

    localparam int ENTRY_W = SEL_W + CFG_PAD_W + DATA_W;
    localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] REM_TWO = CNT_W'(2);

    loader_state_t       state_reg, state_next;
    logic [CNT_W-1:0]    rem_reg, rem_next;
    logic [SEL_W-1:0]    sel_reg, sel_next;
    logic [HOST_W-1:0]   word_reg, word_next;
    logic                err_reg, err_next;
    logic                done_reg, done_next;

    logic                host_fire;
    logic                emitting;
    logic                wr;
    logic [SEL_W-1:0]    hdr_sel;
    logic [CNT_W-1:0]    hdr_cnt;

    assign hdr_sel = host_din[HOST_W-1 -: SEL_W];
    assign hdr_cnt = host_din[CNT_W-1:0];

    // Handshake and write strobe decode from the state register only.
    always_comb begin
        host_ready = (state_reg == ST_HDR) || (state_reg == ST_WORD) ||
                     (state_reg == ST_DRAIN);
        emitting   = (state_reg == ST_EMIT_LO) || (state_reg == ST_EMIT_HI) ||
                     (state_reg == ST_RST_EMIT);
        wr         = emitting && !npu_config_fifo_full;
        host_fire  = host_valid && host_ready;
    end

    // Entry mux: low half, high half, or the fixed NPU reset entry.
    always_comb begin
        npu_config_interface_din = '0;
        case (state_reg)
            ST_EMIT_LO:  npu_config_interface_din = {sel_reg, {CFG_PAD_W{1'b0}}, word_reg[DATA_W-1:0]};
            ST_EMIT_HI:  npu_config_interface_din = {sel_reg, {CFG_PAD_W{1'b0}}, word_reg[HOST_W-1:DATA_W]};
            ST_RST_EMIT: npu_config_interface_din = {SEL_NPU_RST, {(ENTRY_W-SEL_W){1'b0}}};
            default:     npu_config_interface_din = '0;
        endcase
    end

    // Next-state logic: header parsing, payload unpacking and drain counting.
    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        sel_next   = sel_reg;
        word_next  = word_reg;
        err_next   = err_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_HDR: begin
                if (host_fire) begin
                    sel_next = hdr_sel;
                    rem_next = hdr_cnt;
                    if (hdr_sel == SEL_NONE) begin
                        err_next = 1'b1;
                        if (hdr_cnt != '0) state_next = ST_DRAIN;
                        else               done_next  = 1'b1;
                    end else if (hdr_sel == SEL_NPU_RST) begin
                        state_next = ST_RST_EMIT;
                    end else if (hdr_cnt == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ST_WORD;
                    end
                end
            end
            ST_WORD: begin
                if (host_fire) begin
                    word_next  = host_din;
                    state_next = ST_EMIT_LO;
                end
            end
            ST_EMIT_LO, ST_EMIT_HI: begin
                if (wr) begin
                    rem_next = rem_reg - REM_ONE;
                    if (rem_reg == REM_ONE) begin
                        state_next = ST_HDR;
                        done_next  = 1'b1;
                    end else begin
                        state_next = (state_reg == ST_EMIT_LO) ? ST_EMIT_HI : ST_WORD;
                    end
                end
            end
            ST_RST_EMIT: begin
                if (wr) begin
                    state_next = ST_HDR;
                    done_next  = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Each discarded word covers two entries; an odd tail still costs a word.
                if (host_fire) begin
                    if (rem_reg <= REM_TWO) begin
                        rem_next   = '0;
                        state_next = ST_HDR;
                        done_next  = 1'b1;
                    end else begin
                        rem_next = rem_reg - REM_TWO;
                    end
                end
            end
            default: begin
                state_next = ST_HDR;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_HDR;
            rem_reg   <= '0;
            sel_reg   <= '0;
            word_reg  <= '0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            sel_reg   <= sel_next;
            word_reg  <= word_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
        end
    end

    assign npu_config_fifo_write_en = wr;
    assign loader_busy              = (state_reg != ST_HDR);
    assign loader_done              = done_reg;
    assign loader_err               = err_reg;

endmodule

// File: tb/tb_npu_config_loader.sv
// Directed bench for npu_config_loader with a command-level model that
// expands each command into the entries it must produce.
module tb_npu_config_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] host_din = '0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic        full = 1'b0;
    logic [25:0] din;
    logic        write_en;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic exp_err = 1'b0;
    logic toggle_en = 1'b0;
    logic [25:0] exp_q[$];
    logic [25:0] got[$];

    npu_config_loader dut (
        .CLK                      (clk),
        .RST                      (rst),
        .host_din                 (host_din),
        .host_valid               (host_valid),
        .host_ready               (host_ready),
        .npu_config_fifo_full     (full),
        .npu_config_interface_din (din),
        .npu_config_fifo_write_en (write_en),
        .loader_busy              (busy),
        .loader_done              (done),
        .loader_err               (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %h", name, act);
        end
    endtask

    function automatic logic [25:0] entry(input logic [3:0] s, input logic [15:0] h);
        return {s, 6'b0, h};
    endfunction

    // Model: expand one command into the entries the FIFO must receive.
    task automatic model_cmd(input logic [31:0] hdr, input logic [31:0] words[$]);
        logic [3:0]  s;
        logic [15:0] n;
        logic [31:0] w;
        s = hdr[31:28];
        n = hdr[15:0];
        if (s == 4'd8) begin
            exp_err = 1'b1;
        end else if (s == 4'd15) begin
            exp_q.push_back({4'hF, 22'b0});
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = words[i / 2];
                exp_q.push_back(entry(s, (i % 2 == 1) ? w[31:16] : w[15:0]));
            end
        end
        exp_done++;
    endtask

    // Drive point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) full = ~full;
    endtask

    task automatic send_word(input logic [31:0] w);
        int t;
        host_din   = w;
        host_valid = 1'b1;
        t = 0;
        while (!host_ready && t < 200) begin
            tick();
            t++;
        end
        if (t == 200) begin
            tests++; fails++;
            $display("FAIL send_timeout: host_ready stuck at %b, required 1", host_ready);
        end
        tick();
        host_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [31:0] hdr, input logic [31:0] words[$]);
        model_cmd(hdr, words);
        send_word(hdr);
        foreach (words[i]) send_word(words[i]);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 500) begin
            tick();
            t++;
        end
        if (t == 500) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy=%b pending=%0d, required 0/0", busy, exp_q.size());
        end
        tick();
        tick();
    endtask

    // Compare process: every write against the model, plus handshake rules.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done) done_seen++;
            if (full) chk("full_blocks_write", {31'b0, write_en}, 32'd0);
            if (write_en) begin
                chk("ready_low_on_write", {31'b0, host_ready}, 32'd0);
                got.push_back(din);
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: got %h required no write", din);
                end else begin
                    chk("wr_entry", {6'b0, din}, {6'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        logic [31:0] ws[$];

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_ready", {31'b0, host_ready}, 32'd1);
        chk("rst_wr_en", {31'b0, write_en}, 32'd0);
        chk("rst_din", {6'b0, din}, 32'd0);
        chk("rst_busy_err_done", {29'b0, busy, err, done}, 32'd0);
        rst = 1'b0;
        tick();

        // sel=3 cnt=4, even payload
        got.delete();
        exp_done = 0; done_seen = 0;
        ws = '{32'hBBBB_AAAA, 32'hDDDD_CCCC};
        send_cmd({4'd3, 12'h0, 16'd4}, ws);
        wait_idle();
        chk("t1_count", got.size(), 32'd4);
        if (got.size() == 4) begin
            chk("t1_e0", {6'b0, got[0]}, 32'h00C0AAAA);
            chk("t1_e1", {6'b0, got[1]}, 32'h00C0BBBB);
            chk("t1_e2", {6'b0, got[2]}, 32'h00C0CCCC);
            chk("t1_e3", {6'b0, got[3]}, 32'h00C0DDDD);
        end
        chk("t1_done", done_seen, 32'd1);

        // sel=9 cnt=3, odd tail dropped
        got.delete();
        ws = '{32'h2222_1111, 32'h4444_3333};
        send_cmd({4'd9, 12'hABC, 16'd3}, ws);
        wait_idle();
        chk("t2_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("t2_e0", {6'b0, got[0]}, 32'h02401111);
            chk("t2_e2", {6'b0, got[2]}, 32'h02403333);
        end

        // sel=15 with FIFO full for 5 cycles
        got.delete();
        full = 1'b1;
        ws = {};
        model_cmd({4'd15, 12'h0, 16'd7}, ws);
        send_word({4'd15, 12'h0, 16'd7});
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_wr", {31'b0, write_en}, 32'd0);
            chk("t3_hold_din", {6'b0, din}, 32'h03C00000);
            chk("t3_hold_ready", {31'b0, host_ready}, 32'd0);
            tick();
        end
        full = 1'b0;
        wait_idle();
        chk("t3_count", got.size(), 32'd1);

        // sel=8 cnt=5: drained, sticky error, next command normal
        got.delete();
        ws = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        send_cmd({4'd8, 12'h0, 16'd5}, ws);
        wait_idle();
        chk("t4_no_writes", got.size(), 32'd0);
        chk("t4_err", {31'b0, err}, {31'b0, exp_err});
        ws = '{32'h0000_1234};
        send_cmd({4'd0, 12'h0, 16'd1}, ws);
        wait_idle();
        chk("t4_next_count", got.size(), 32'd1);
        if (got.size() == 1) chk("t4_next_e0", {6'b0, got[0]}, 32'h00001234);
        chk("t4_err_sticky", {31'b0, err}, 32'd1);

        // sel=13 cnt=6 with full toggling every cycle
        got.delete();
        toggle_en = 1'b1;
        ws = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005};
        send_cmd({4'd13, 12'h0, 16'd6}, ws);
        wait_idle();
        toggle_en = 1'b0;
        full = 1'b0;
        chk("t5_count", got.size(), 32'd6);
        if (got.size() == 6) chk("t5_e5", {6'b0, got[5]}, 32'h03400006);
        chk("t5_done_total", done_seen, exp_done);

        // Reset during EMIT_HI aborts the command and clears the error
        got.delete();
        ws = '{32'h0BBB_0AAA};
        model_cmd({4'd1, 12'h0, 16'd4}, ws);
        send_word({4'd1, 12'h0, 16'd4});
        send_word(32'h0BBB_0AAA);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_wr_after_rst", {31'b0, write_en}, 32'd0);
        chk("t6_err_cleared", {31'b0, err}, 32'd0);
        chk("t6_busy_after_rst", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        got.delete();
        tick();
        ws = '{32'h0000_5A5A};
        send_cmd({4'd2, 12'h0, 16'd1}, ws);
        wait_idle();
        chk("t6_count", got.size(), 32'd1);
        if (got.size() == 1) chk("t6_e0", {6'b0, got[0]}, 32'h00805A5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/npu_config_loader.md
Name: npu_config_loader

Overview:
- Upstream feeder for the NPU config interface FIFO.
- Accepts a 32-bit host command stream over a valid/ready handshake. Each command is one header word followed by packed 16-bit payload entries.
- Unpacks each command into 26-bit config entries {sel[3:0], 6'b0, data[15:0]} and writes them to the config FIFO, stalling on FIFO full.
- Flags illegal targets and reports command completion.

Parameters:
- HOST_W, 32, host word width; must equal 2*DATA_W.
- DATA_W, 16, config payload width.
- SEL_W, 4, target-select width.
- CNT_W, 16, payload-entry count width.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- host_din  in  32  command word (header or payload).
- host_valid  in  1  host word valid.
- host_ready  out  1  loader accepts host_din this cycle.
- npu_config_fifo_full  in  1  full flag from the config FIFO.
- npu_config_interface_din  out  26  entry to the config FIFO.
- npu_config_fifo_write_en  out  1  FIFO write strobe.
- loader_busy  out  1  command in progress (state != HDR).
- loader_done  out  1  one-cycle pulse when a command completes.
- loader_err  out  1  sticky illegal-select flag; cleared only by RST.

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high. All state is updated on the rising edge of CLK.
- A host transfer occurs on host_valid && host_ready.
- Header word fields: [31:28] sel; [27:16] reserved, ignored; [15:0] cnt = number of 16-bit entries.
- Payload words: low half [15:0] is emitted first, then the high half [31:16]. If cnt is odd, the high half of the final word is discarded.
- Entry format: npu_config_interface_din = {sel_q, 6'b000000, half}.
- States:
  - HDR: host_ready=1. On header accept, latch sel_q and rem=cnt, then branch:
    - sel==8 → set loader_err. If cnt!=0 go to DRAIN, else pulse done and stay in HDR.
    - sel==15 → go to RST_EMIT; cnt is ignored and no payload words follow.
    - cnt==0 → pulse done, stay in HDR.
    - otherwise → go to WORD.
  - WORD: host_ready=1. On accept, latch word_q and go to EMIT_LO.
  - EMIT_LO: present word_q[15:0]. When a write occurs, rem--. Then: rem was 1 → HDR with done pulse; else → EMIT_HI.
  - EMIT_HI: present word_q[31:16]. When a write occurs, rem--. Then: rem was 1 → HDR with done pulse; else → WORD.
  - RST_EMIT: present {4'hF, 22'b0}. When a write occurs → HDR with done pulse.
  - DRAIN: host_ready=1. Consume ceil(cnt/2) words with no FIFO writes. After the last word → HDR with done pulse.
- Write strobe: npu_config_fifo_write_en = (state in {EMIT_LO, EMIT_HI, RST_EMIT}) && !npu_config_fifo_full. It is combinational from the state register and the full input. State and rem advance only on a write.
- While full is high, npu_config_interface_din holds stable.
- host_ready is 0 in EMIT_LO, EMIT_HI and RST_EMIT.
- Throughput, with FIFO never full:
  - 1 cycle per entry.
  - 1 cycle per payload word fetch.
  - Steady state = 3 cycles per word.
- loader_done is registered: it is high during the cycle after the completing transition.
- Reset: state=HDR, rem=0, sel_q=0, word_q=0, loader_err=0, loader_done=0.
  - Consequent outputs during and after reset: host_ready=1, write_en=0, din=0.
  - RST asserted mid-command aborts the command; the next word after reset is parsed as a header.
- cnt=16'hFFFF is legal. rem is CNT_W bits and never wraps, because it only decrements from a value ≥1.
- host_valid held low in WORD or DRAIN means the loader waits indefinitely; no timeout.

Decomposition:
- Shared package npu_cfg_pkg holds:
  - SEL_W and DATA_W.
  - Entry-format constants: the pad width 6.
  - Target-select encodings: WEIGHT0..7=0..7, SEL_NONE=8, IN_FMT=9, OUT_FMT=10, IN_CNT=11, OUT_CNT=12, SCHED=13, OFFSET=14, NPU_RST=15.
  - The loader state enum.
- No sub-module is needed; the block is a single FSM plus datapath registers.

Test Plan:
- Header sel=3 cnt=4, then words 32'hBBBB_AAAA and 32'hDDDD_CCCC → FIFO writes 26'h0C0AAAA, 26'h0C0BBBB, 26'h0C0CCCC, 26'h0C0DDDD; loader_done pulses once.
- Header sel=9 cnt=3, then words 32'h2222_1111 and 32'h4444_3333 → writes 0x1111, 0x2222, 0x3333 with sel 9; 0x4444 is dropped.
- Header sel=15, with full held high for 5 cycles → write_en stays 0 and din stable at 26'h3C00000 for those cycles; exactly one write once full drops; host_ready=0 throughout.
- Header sel=8 cnt=5, then 3 payload words → no writes; loader_err=1 and stays set; the next header sel=0 cnt=1 is processed normally.
- full toggled every other cycle during a cnt=6 command on sel=13 → all 6 entries written in order, with no duplicates and no losses.
- RST asserted while in EMIT_HI of a sel=1 cnt=4 command → write_en=0 next cycle and loader_err=0; the following header sel=2 cnt=1 with word 32'h0000_5A5A → single write 26'h0805A5A.
